bram_stream_writer: RTL and testbench

Fills a `true_dpbram` instance from a valid/ready word stream through the BRAM's port-0 signals (`addr`/`ce`/`we`/`d`), starting at a programmable base address, for a programmed word count. It is the write-side counterpart of `data_mover_bram`, which only reads node/weight BRAMs. It replaces testbench back-door loading of `ram[]` with a synthesizable loader, so the FC core can be fed from a DMA or host stream. Control uses the same `i_run` / `o_idle` / `o_done` style as `data_mover_bram`.

---
 rtl/fc_core_pkg.sv | 16 +
 rtl/bram_stream_writer.sv | 107 ++++++++++
 tb/tb_bram_stream_writer.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/fc_core_pkg.sv
// Constants and FSM encoding shared by the FC core BRAM movers
// (data_mover_bram and bram_stream_writer).
package fc_core_pkg;

    localparam int unsigned CNT_BIT_DEF  = 31;
    localparam int unsigned DWIDTH_DEF   = 32;
    localparam int unsigned AWIDTH_DEF   = 12;
    localparam int unsigned MEM_SIZE_DEF = 4096;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/bram_stream_writer.sv
// Loads a true_dpbram through its port-0 signals from a valid/ready word stream,
// starting at a latched base address for a latched (depth-clamped) word count.
module bram_stream_writer
    import fc_core_pkg::*;
#(
    parameter int unsigned CNT_BIT  = CNT_BIT_DEF,
    parameter int unsigned DWIDTH   = DWIDTH_DEF,
    parameter int unsigned AWIDTH   = AWIDTH_DEF,
    parameter int unsigned MEM_SIZE = MEM_SIZE_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               i_run,
    input  logic [CNT_BIT-1:0] i_num_cnt,
    input  logic [AWIDTH-1:0]  i_base_addr,
    output logic               o_idle,
    output logic               o_write,
    output logic               o_done,
    input  logic               s_valid,
    output logic               s_ready,
    input  logic [DWIDTH-1:0]  s_data,
    output logic [AWIDTH-1:0]  addr_b,
    output logic               ce_b,
    output logic               we_b,
    output logic [DWIDTH-1:0]  d_b,
    input  logic [DWIDTH-1:0]  q_b
);

    localparam logic [CNT_BIT-1:0] MaxCnt = CNT_BIT'(MEM_SIZE);

    state_t             state;
    logic [CNT_BIT-1:0] num_q;
    logic [CNT_BIT-1:0] cnt_q;
    logic [AWIDTH-1:0]  base_q;
    logic               fire;
    logic               unused_q_b;

    assign fire       = s_valid & s_ready;
    assign unused_q_b = ^q_b;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            num_q   <= '0;
            cnt_q   <= '0;
            base_q  <= '0;
            o_idle  <= 1'b1;
            o_write <= 1'b0;
            o_done  <= 1'b0;
            s_ready <= 1'b0;
            ce_b    <= 1'b0;
            we_b    <= 1'b0;
            addr_b  <= '0;
            d_b     <= '0;
        end else begin
            ce_b <= 1'b0;
            we_b <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (i_run) begin
                        o_idle <= 1'b0;
                        if (i_num_cnt == '0) begin
                            state  <= S_DONE;
                            o_done <= 1'b1;
                        end else begin
                            state   <= S_WRITE;
                            o_write <= 1'b1;
                            s_ready <= 1'b1;
                            num_q   <= (i_num_cnt > MaxCnt) ? MaxCnt : i_num_cnt;
                            base_q  <= i_base_addr;
                            cnt_q   <= '0;
                        end
                    end
                end
                S_WRITE: begin
                    if (fire) begin
                        ce_b   <= 1'b1;
                        we_b   <= 1'b1;
                        // Address wraps modulo the BRAM depth.
                        addr_b <= base_q + cnt_q[AWIDTH-1:0];
                        d_b    <= s_data;
                        cnt_q  <= cnt_q + CNT_BIT'(1);
                        if (cnt_q == num_q - CNT_BIT'(1)) begin
                            state   <= S_DONE;
                            o_write <= 1'b0;
                            s_ready <= 1'b0;
                            o_done  <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    state  <= S_IDLE;
                    o_done <= 1'b0;
                    o_idle <= 1'b1;
                end
                default: begin
                    state   <= S_IDLE;
                    o_idle  <= 1'b1;
                    o_write <= 1'b0;
                    o_done  <= 1'b0;
                    s_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bram_stream_writer.sv
// Self-checking bench for bram_stream_writer: table of transfers, random transfers,
// mid-transfer reset and restart, checked against a queue-based stream/BRAM model.
module tb_bram_stream_writer;

    localparam int MEM = 4096;

    logic        clk;
    logic        reset;
    logic        i_run;
    logic [30:0] i_num_cnt;
    logic [11:0] i_base_addr;
    logic        o_idle, o_write, o_done;
    logic        s_valid, s_ready;
    logic [31:0] s_data;
    logic [11:0] addr_b;
    logic        ce_b, we_b;
    logic [31:0] d_b;
    logic [31:0] q_b;

    bram_stream_writer dut (
        .clk         (clk),
        .reset       (reset),
        .i_run       (i_run),
        .i_num_cnt   (i_num_cnt),
        .i_base_addr (i_base_addr),
        .o_idle      (o_idle),
        .o_write     (o_write),
        .o_done      (o_done),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_data      (s_data),
        .addr_b      (addr_b),
        .ce_b        (ce_b),
        .we_b        (we_b),
        .d_b         (d_b),
        .q_b         (q_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int cnt;
        int base;
        int pct;
        bit fixed;
        int exp_writes;
        int exp_first;
        int exp_last;
        int exp_done_cyc;  // -1: not checked (backpressured stream)
    } vec_t;

    int          tests;
    int          failed;
    logic [31:0] words[$];
    int          got_addr[$];
    logic [31:0] got_data[$];
    int          done_cnt;
    int          done_cyc;
    bit          done_strobe;
    bit          ready_seen;

    task automatic check(input string name, input longint act, input longint exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic run_xfer(input int cnt, input int base, input int pct, input bit fixed,
                            input int abort_at);
        int eff, idx, cyc, extra;
        bit pv, pr, finished;
        eff = (cnt > MEM) ? MEM : cnt;
        words.delete();
        got_addr.delete();
        got_data.delete();
        for (int i = 0; i < eff + 3; i++) begin
            if (fixed) words.push_back({8'(4*i+1), 8'(4*i+2), 8'(4*i+3), 8'(4*i+4)});
            else       words.push_back($urandom);
        end
        done_cnt = 0; done_cyc = -1; done_strobe = 0; ready_seen = 0;
        i_run = 1'b1; i_num_cnt = 31'(cnt); i_base_addr = 12'(base);
        s_valid = 1'b0;
        pv = 0; pr = 0; idx = 0; cyc = 0; finished = 0;
        while (!finished) begin
            @(posedge clk); #1;
            cyc++;
            i_run = 1'b0;
            if (pv && pr) idx++;
            if (ce_b && we_b) begin
                got_addr.push_back(int'(addr_b));
                got_data.push_back(d_b);
            end
            if (o_done) begin
                done_cnt++;
                done_cyc    = cyc;
                done_strobe = ce_b && we_b;
            end
            if (s_ready) ready_seen = 1;
            if (done_cnt > 0 && o_idle) begin
                finished = 1;
            end else if (cyc > 20000) begin
                check("xfer_timeout", cyc, 0);
                finished = 1;
            end else if (abort_at > 0 && got_addr.size() == abort_at) begin
                // Keep the stream offering words while reset is applied.
                reset = 1'b1; s_valid = 1'b1; s_data = words[idx];
                @(posedge clk); #1;
                check("abort_strobe_drop", ce_b, 0);
                check("abort_idle", o_idle, 1);
                check("abort_ready", s_ready, 0);
                reset = 1'b0;
                extra = 0;
                for (int k = 0; k < 5; k++) begin
                    @(posedge clk); #1;
                    if (ce_b && we_b) extra++;
                    if (o_done) done_cnt++;
                end
                check("abort_no_write", extra, 0);
                check("abort_idle_after", o_idle, 1);
                finished = 1;
            end else begin
                // Late i_run with different settings must be ignored mid-transfer.
                if (cyc == 3 && o_write) begin
                    i_run = 1'b1; i_num_cnt = 31'd2; i_base_addr = 12'd123;
                end
                s_valid = ($urandom_range(99) < pct) && (idx < words.size());
                s_data  = s_valid ? words[idx] : $urandom;
                pv = s_valid;
                pr = s_ready;
            end
        end
        s_valid = 1'b0;
        i_run   = 1'b0;
    endtask

    task automatic check_xfer(input string tag, input int base, input int exp_writes,
                              input int exp_first, input int exp_last, input int exp_done_cyc);
        int errs;
        check({tag, "_writes"}, got_addr.size(), exp_writes);
        check({tag, "_done_once"}, done_cnt, 1);
        if (got_addr.size() > 0) begin
            check({tag, "_first_addr"}, got_addr[0], exp_first);
            check({tag, "_last_addr"}, got_addr[got_addr.size()-1], exp_last);
        end
        errs = 0;
        for (int i = 0; i < got_addr.size(); i++) begin
            if (got_addr[i] != (base + i) % MEM || got_data[i] !== words[i]) errs++;
        end
        check({tag, "_seq_errs"}, errs, 0);
        if (exp_writes > 0) check({tag, "_done_with_last_strobe"}, done_strobe, 1);
        else                check({tag, "_ready_never"}, ready_seen, 0);
        if (exp_done_cyc >= 0) check({tag, "_done_cycle"}, done_cyc, exp_done_cyc);
    endtask

    vec_t vecs[7];

    initial begin
        int cnt, base, pct, last;
        tests = 0; failed = 0;
        vecs[0] = '{4,    0,    100, 1, 4,    0,    3,    5};
        vecs[1] = '{4,    4094, 100, 0, 4,    4094, 1,    5};
        vecs[2] = '{1,    100,  100, 0, 1,    100,  100,  2};
        vecs[3] = '{0,    7,    100, 0, 0,    -1,   -1,   1};
        vecs[4] = '{5000, 0,    100, 0, 4096, 0,    4095, 4097};
        vecs[5] = '{4096, 0,    50,  0, 4096, 0,    4095, -1};
        vecs[6] = '{17,   4000, 30,  0, 17,   4000, 4016, -1};

        reset = 1'b1; i_run = 1'b0; i_num_cnt = '0; i_base_addr = '0;
        s_valid = 1'b0; s_data = '0; q_b = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_idle", o_idle, 1);
        check("rst_write", o_write, 0);
        check("rst_done", o_done, 0);
        check("rst_ready", s_ready, 0);
        check("rst_ce", ce_b, 0);
        check("rst_we", we_b, 0);
        check("rst_addr", addr_b, 0);
        check("rst_data", d_b, 0);
        reset = 1'b0;
        @(posedge clk); #1;

        for (int v = 0; v < 7; v++) begin
            run_xfer(vecs[v].cnt, vecs[v].base, vecs[v].pct, vecs[v].fixed, 0);
            check_xfer($sformatf("vec%0d", v), vecs[v].base, vecs[v].exp_writes,
                       vecs[v].exp_first, vecs[v].exp_last, vecs[v].exp_done_cyc);
        end

        for (int r = 0; r < 6; r++) begin
            cnt  = $urandom_range(1, 40);
            base = $urandom_range(0, MEM - 1);
            pct  = (r % 2 == 0) ? 100 : $urandom_range(20, 90);
            last = (base + cnt - 1) % MEM;
            run_xfer(cnt, base, pct, 0, 0);
            check_xfer($sformatf("rand%0d", r), base, cnt, base, last,
                       (pct == 100) ? cnt + 1 : -1);
        end

        run_xfer(100, 0, 100, 0, 10);
        check("abort_writes", got_addr.size(), 10);
        check("abort_no_done", done_cnt, 0);
        check("abort_last_addr", got_addr[got_addr.size()-1], 9);
        check("abort_last_data", got_data[got_data.size()-1], words[9]);

        run_xfer(20, 50, 100, 0, 0);
        check_xfer("restart", 50, 20, 50, 69, 21);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
